// File: rtl/sram_req_master.sv
// sram_req_master
//   Initiator side of a single-port SRAM (1-cycle read latency). Turns a
//   valid/ready request stream into SRAM accesses and returns read data on a
//   valid/ready response stream through a 2-entry in-order response buffer.
//   Optional post-reset sweep writes INIT_VALUE to every word; it is enabled
//   by defining SRAM_REQ_MASTER_INIT_EN (default build: no sweep, straight to RUN).
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   init_done_o             high in RUN (requests may be accepted)
//   req_valid_i/req_ready_o request handshake; req_we_i/addr/wdata/be payload
//   rsp_valid_o/rsp_ready_i read response handshake; rsp_rdata_o, rsp_err_o
//                           (err = read address >= NUM_WORDS, data forced to 0)
//   sram_*                  SRAM port (req/we/addr/wdata/be out, rdata in)
// While rst_i is high all outputs show their reset values.
module sram_req_master #(
  parameter int unsigned            DATA_WIDTH = 64,
  parameter int unsigned            NUM_WORDS  = 1024,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0,
  localparam int unsigned           AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned           BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_done_o,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BW-1:0]         req_be_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [AW-1:0]         sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [BW-1:0]         sram_be_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  typedef struct packed {
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } rsp_t;

  state_e     state_q, state_d;
  rsp_t       buf_q [2];
  logic       rd_ptr_q, wr_ptr_q;
  logic [1:0] count_q;
  logic       inflight_q, inflight_oob_q;

  logic       req_oob, accept, has_room;
  logic       pop, push, buf_pop;
  rsp_t       in_rsp, head;

`ifdef SRAM_REQ_MASTER_INIT_EN
  logic [AW-1:0] sweep_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != ST_INIT) sweep_q <= '0;
    else                             sweep_q <= sweep_q + 1'b1;
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef SRAM_REQ_MASTER_INIT_EN
      state_q <= ST_INIT;
`else
      state_q <= ST_RUN;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  assign req_oob  = (32'(req_addr_i) >= NUM_WORDS);
  // Occupancy counts the read issued last cycle, so the buffer can never overflow.
  assign has_room = (count_q + {1'b0, inflight_q}) < 2'd2;
  assign accept   = req_valid_i & req_ready_o;

  always_comb begin
    state_d      = state_q;
    init_done_o  = 1'b0;
    req_ready_o  = 1'b0;
    sram_req_o   = 1'b0;
    sram_we_o    = req_we_i;
    sram_addr_o  = req_addr_i;
    sram_wdata_o = req_wdata_i;
    sram_be_o    = req_be_i;
    case (state_q)
      ST_INIT: begin
`ifdef SRAM_REQ_MASTER_INIT_EN
        sram_req_o   = !rst_i;
        sram_we_o    = 1'b1;
        sram_addr_o  = sweep_q;
        sram_wdata_o = INIT_VALUE;
        sram_be_o    = '1;
        if (!rst_i && sweep_q == AW'(NUM_WORDS - 1)) state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        init_done_o = !rst_i;
        req_ready_o = !rst_i && has_room;
        sram_req_o  = !rst_i && has_room && req_valid_i && !req_oob;
      end
      default: state_d = state_q;
    endcase
  end

  // The read returning this cycle is presented directly when the buffer is
  // empty (1-cycle response latency); it is stored only if not taken now,
  // which keeps the output stable under backpressure.
  assign in_rsp = '{err: inflight_oob_q, data: inflight_oob_q ? '0 : sram_rdata_i};

  always_comb begin
    head = '0;
    if (count_q != 2'd0) head = buf_q[rd_ptr_q];
    else if (inflight_q) head = in_rsp;
    rsp_valid_o = !rst_i && (count_q != 2'd0 || inflight_q);
    rsp_err_o   = !rst_i && head.err;
    rsp_rdata_o = rst_i ? '0 : head.data;
  end

  assign pop     = rsp_valid_o & rsp_ready_i;
  assign buf_pop = pop & (count_q != 2'd0);
  assign push    = inflight_q & ~(pop & (count_q == 2'd0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q     <= 1'b0;
      inflight_oob_q <= 1'b0;
      count_q        <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      inflight_q     <= accept & ~req_we_i;
      inflight_oob_q <= accept & ~req_we_i & req_oob;
      if (push) begin
        buf_q[wr_ptr_q] <= in_rsp;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (buf_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, buf_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_req_master.sv
module tb_sram_req_master;
  localparam int unsigned DW = 64;
  localparam int unsigned NW = 12;
  localparam int unsigned AW = 4;
  localparam int unsigned BW = 8;
  localparam logic [DW-1:0] INIT = 64'hA5A5_A5A5_A5A5_A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done, req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [BW-1:0] sram_be;

  always #5 clk = ~clk;

  sram_req_master #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .INIT_VALUE(INIT)) dut (
    .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .sram_req_o(sram_req), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_be_o(sram_be),
    .sram_rdata_i(sram_rdata)
  );

  // Simple single-port SRAM with registered read data.
  logic [DW-1:0] sram_mem [16];
  always @(posedge clk) begin
    if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < BW; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  // Reference model: memory contents plus the queue of responses owed.
  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] ref_mem [NW];
  rsp_t          pend [$];
  int unsigned   errors = 0;
  int unsigned   checks = 0;
  logic [DW-1:0] last_rdata;
  logic          last_err;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One RUN-mode cycle: drive at negedge, check outputs, advance the model.
  task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be,
                       input logic rr, output logic acc);
    logic exp_ready, exp_valid, in_range;
    rsp_t hd;
    @(negedge clk);
    rst = 1'b0;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; req_be = be;
    rsp_ready = rr;
    #1;
    exp_ready = pend.size() < 2;
    exp_valid = pend.size() > 0;
    acc       = v && exp_ready;
    in_range  = (a < NW);
    chk("init_done", init_done, 1'b1);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_valid);
    if (exp_valid) begin
      hd = pend[0];
      chk("rsp_rdata", rsp_rdata, hd.data);
      chk("rsp_err", rsp_err, hd.err);
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
      if (rr) void'(pend.pop_front());
    end
    chk("sram_req", sram_req, acc && in_range);
    if (acc && in_range) begin
      chk("sram_addr", sram_addr, a);
      chk("sram_we", sram_we, we);
      if (we) begin
        chk("sram_wdata", sram_wdata, d);
        chk("sram_be", sram_be, be);
      end
    end
    if (acc) begin
      if (we) begin
        if (in_range)
          for (int b = 0; b < BW; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        pend.push_back('{err: !in_range, data: in_range ? ref_mem[a] : '0});
      end
    end
  endtask

  task automatic do_reset(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
      #1;
      chk("rst_init_done", init_done, 1'b0);
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, '0);
      chk("rst_sram_req", sram_req, 1'b0);
    end
    pend.delete();
  endtask

  // Checks the first n cycles of the post-reset sweep.
  task automatic sweep(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(i); rsp_ready = 1'b1;
      #1;
      chk("sweep_init_done", init_done, 1'b0);
      chk("sweep_req_ready", req_ready, 1'b0);
      chk("sweep_rsp_valid", rsp_valid, 1'b0);
      chk("sweep_sram_req", sram_req, 1'b1);
      chk("sweep_sram_addr", sram_addr, AW'(i));
      chk("sweep_sram_we", sram_we, 1'b1);
      chk("sweep_sram_be", sram_be, {BW{1'b1}});
      chk("sweep_sram_wdata", sram_wdata, INIT);
    end
    if (n == NW) for (int unsigned i = 0; i < NW; i++) ref_mem[i] = INIT;
  endtask

  task automatic bring_up();
    logic acc;
`ifdef SRAM_REQ_MASTER_INIT_EN
    sweep(NW);
`else
    for (int unsigned i = 0; i < NW; i++) cycle(1'b1, 1'b1, AW'(i), INIT, '1, 1'b1, acc);
`endif
  endtask

  initial begin
    logic          acc, acc_prev, hv, hwe, rr;
    logic [AW-1:0] ha;
    logic [DW-1:0] hd;
    logic [BW-1:0] hbe;

    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    do_reset(3);
    bring_up();

    // Read back an initialised word.
    last_rdata = 'x; last_err = 1'bx;
    cycle(1'b1, 1'b0, 4'd7, '0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    chk("t1_rdata", last_rdata, INIT);
    chk("t1_err", last_err, 1'b0);

    // Partial-byte write merges with the initial value.
    last_rdata = 'x;
    cycle(1'b1, 1'b1, 4'd3, 64'h1122_3344_5566_7788, 8'h0F, 1'b1, acc);
    cycle(1'b1, 1'b0, 4'd3, '0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    chk("t2_rdata", last_rdata, 64'hA5A5_A5A5_5566_7788);

    // Back-to-back reads with no backpressure.
    for (int a = 0; a < 4; a++) cycle(1'b1, 1'b0, AW'(a), '0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

    // Backpressure: only two reads fit, then drain.
    ha = 4'd4;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b0, ha, '0, '0, 1'b0, acc);
      if (acc) ha = ha + 4'd1;
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

    // Out-of-range read and write.
    last_err = 1'bx;
    cycle(1'b1, 1'b0, 4'd13, '0, '0, 1'b1, acc);
    cycle(1'b1, 1'b1, 4'd14, 64'hDEAD_BEEF_0000_1111, '1, 1'b1, acc);
    chk("t5_err", last_err, 1'b1);
    cycle(1'b1, 1'b0, 4'd12, '0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

    // Randomised traffic with held requests under backpressure.
    hv = 1'b0; hwe = 1'b0; ha = '0; hd = '0; hbe = '0; acc_prev = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (!hv || acc_prev) begin
        hv  = ($urandom_range(0, 3) != 0);
        hwe = 1'($urandom_range(0, 1));
        ha  = AW'($urandom_range(0, 15));
        hd  = {$urandom, $urandom};
        hbe = BW'($urandom);
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle(hv, hwe, ha, hd, hbe, rr, acc);
      acc_prev = acc;
    end
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);

    // Reset with a response buffered: it must vanish.
    cycle(1'b1, 1'b0, 4'd2, '0, '0, 1'b0, acc);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b0, acc);
    do_reset(1);
`ifdef SRAM_REQ_MASTER_INIT_EN
    sweep(5);
    do_reset(1);
    sweep(NW);
`else
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
`endif
    last_rdata = 'x;
    cycle(1'b1, 1'b0, 4'd3, '0, '0, 1'b1, acc);
    cycle(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
`ifdef SRAM_REQ_MASTER_INIT_EN
    chk("t6_rdata", last_rdata, INIT);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
